// File: rtl/fft_input_reorder_1_pkg.sv
// fft_input_reorder_1_pkg: shared FFT constants (N, DW, LOG2N) and the bit-reversal index helper
package fft_input_reorder_1_pkg;
  localparam int N = 8;
  localparam int DW = 12;
  localparam int LOG2N = $clog2(N);
  function automatic int bitrev(input int v, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if (i < bits) r = {r[30:0], v[i]};
    return r;
  endfunction
endpackage

// File: rtl/fft_input_reorder_1.sv
// fft_input_reorder_1: ping-pong bit-reversal frame buffer; sample_* in (valid/ready), frame_* out (valid/ready), flush drops partial frame, fill_level = samples in write bank
import fft_input_reorder_1_pkg::*;
module fft_input_reorder_1 #(
  parameter int N = fft_input_reorder_1_pkg::N,
  parameter int DW = fft_input_reorder_1_pkg::DW,
  localparam int LOG2N = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DW-1:0]     sample_real,
  input  logic [DW-1:0]     sample_img,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [N*DW-1:0]   frame_real,
  output logic [N*DW-1:0]   frame_img,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [LOG2N-1:0]  fill_level
);
  logic [DW-1:0] mem_re [2][N];
  logic [DW-1:0] mem_im [2][N];
  logic [1:0] full;
  logic wr_bank, rd_bank, accept, last;
  logic [LOG2N-1:0] wr_cnt, wa;
  assign sample_ready = !full[wr_bank];
  assign frame_valid = full[rd_bank];
  assign fill_level = wr_cnt;
  assign accept = sample_valid && sample_ready && !flush;
  assign last = wr_cnt == LOG2N'(N - 1);
  assign wa = LOG2N'(bitrev(int'(wr_cnt), LOG2N));
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_re[wr_bank][wa] <= sample_real;
      mem_im[wr_bank][wa] <= sample_img;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full <= '0;
    end else begin
      if (flush) wr_cnt <= '0;
      else if (accept) wr_cnt <= wr_cnt + 1'b1;
      if (accept && last) begin
        full[wr_bank] <= 1'b1;
        wr_bank <= ~wr_bank;
      end
      if (frame_valid && frame_ready) begin
        full[rd_bank] <= 1'b0;
        rd_bank <= ~rd_bank;
      end
    end
  end
  for (genvar k = 0; k < N; k++) begin : g_out
    assign frame_real[DW*k +: DW] = mem_re[rd_bank][k];
    assign frame_img[DW*k +: DW] = mem_im[rd_bank][k];
  end
endmodule

// File: tb/tb_fft_input_reorder_1.sv
// tb_fft_input_reorder_1: randomized self-checking bench against a queue-based frame model
module tb_fft_input_reorder_1;
  localparam int N = 8, DW = 12, LW = 3;
  typedef struct { logic [N*DW-1:0] re, im; } frame_t;
  logic clk = 0, rst = 1, flush = 0, sample_valid = 0, frame_ready = 0;
  logic sample_ready, frame_valid;
  logic [DW-1:0] sample_real = 0, sample_img = 0;
  logic [N*DW-1:0] frame_real, frame_img, hold;
  logic [LW-1:0] fill_level;
  int checks = 0, errors = 0;
  int brt[N] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [DW-1:0] seq_exp[N] = '{1, 5, 3, 7, 2, 6, 4, 8};
  logic [DW-1:0] pr[$], pi[$];
  frame_t fq[$];
  always #5 clk = ~clk;
  fft_input_reorder_1 dut (.clk(clk), .rst(rst), .flush(flush), .sample_real(sample_real), .sample_img(sample_img),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .frame_real(frame_real), .frame_img(frame_img),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .fill_level(fill_level));
  task automatic step(input logic v, input logic [DW-1:0] r, input logic [DW-1:0] i, input logic fr, input logic fl);
    logic acc, hs;
    frame_t f;
    sample_valid = v; sample_real = r; sample_img = i; frame_ready = fr; flush = fl;
    acc = v && fq.size() < 2 && !fl;
    hs = fr && fq.size() > 0;
    @(posedge clk);
    if (hs) fq.delete(0);
    if (fl) begin pr.delete(); pi.delete(); end
    if (acc) begin pr.push_back(r); pi.push_back(i); end
    if (pr.size() == N) begin
      for (int k = 0; k < N; k++) begin
        f.re[DW*k +: DW] = pr[brt[k]];
        f.im[DW*k +: DW] = pi[brt[k]];
      end
      fq.push_back(f);
      pr.delete(); pi.delete();
    end
    @(negedge clk);
  endtask
  task automatic drain();
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
  endtask
  task automatic test_reset();
    #1;
    checks += 3;
    if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset ready got %b exp 1", sample_ready); end
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset valid got %b exp 0", frame_valid); end
    if (fill_level !== '0) begin errors++; $display("FAIL reset fill got %0d exp 0", fill_level); end
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_directed();
    for (int j = 1; j <= N; j++) begin
      step(1, DW'(j), 0, 0, 0);
      checks++;
      if (frame_valid !== (j == N)) begin errors++; $display("FAIL directed valid s%0d got %b exp %b", j, frame_valid, j == N); end
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (frame_real[DW*k +: DW] !== seq_exp[k]) begin errors++; $display("FAIL directed elem%0d got %0d exp %0d", k, frame_real[DW*k +: DW], seq_exp[k]); end
    end
  endtask
  task automatic test_backpressure();
    hold = frame_real;
    for (int j = 0; j < 2 * N; j++) begin
      step(1, DW'($urandom), DW'($urandom), 0, 0);
      checks += 3;
      if (sample_ready !== (j < N - 1)) begin errors++; $display("FAIL bp ready j%0d got %b exp %b", j, sample_ready, j < N - 1); end
      if (frame_valid !== 1'b1) begin errors++; $display("FAIL bp valid j%0d got %b exp 1", j, frame_valid); end
      if (frame_real !== hold) begin errors++; $display("FAIL bp hold j%0d got %h exp %h", j, frame_real, hold); end
    end
    step(0, 0, 0, 1, 0);
    checks += 4;
    if (frame_valid !== 1'b1) begin errors++; $display("FAIL bp next valid got %b exp 1", frame_valid); end
    if (sample_ready !== 1'b1) begin errors++; $display("FAIL bp next ready got %b exp 1", sample_ready); end
    if (frame_real !== fq[0].re) begin errors++; $display("FAIL bp next re got %h exp %h", frame_real, fq[0].re); end
    if (frame_img !== fq[0].im) begin errors++; $display("FAIL bp next im got %h exp %h", frame_img, fq[0].im); end
    step(0, 0, 0, 1, 0);
    checks++;
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL bp empty valid got %b exp 0", frame_valid); end
  endtask
  task automatic test_back_to_back();
    int seen;
    seen = 0;
    drain();
    for (int j = 0; j < 5 * N; j++) begin
      step(1, DW'($urandom), DW'($urandom), 1, 0);
      checks += 3;
      if (sample_ready !== 1'b1) begin errors++; $display("FAIL b2b ready j%0d got %b exp 1", j, sample_ready); end
      if (frame_valid !== (fq.size() > 0)) begin errors++; $display("FAIL b2b valid j%0d got %b exp %b", j, frame_valid, fq.size() > 0); end
      if (fill_level !== LW'(pr.size())) begin errors++; $display("FAIL b2b fill j%0d got %0d exp %0d", j, fill_level, pr.size()); end
      if (frame_valid) begin
        seen++;
        checks++;
        if (fq.size() == 0 || frame_real !== fq[0].re || frame_img !== fq[0].im) begin errors++; $display("FAIL b2b frame j%0d got %h", j, frame_real); end
      end
    end
    checks++;
    if (seen != 5) begin errors++; $display("FAIL b2b frames got %0d exp 5", seen); end
  endtask
  task automatic test_flush();
    drain();
    for (int j = 0; j < 3; j++) step(1, DW'($urandom), DW'($urandom), 0, 0);
    step(1, 12'h123, 12'h456, 0, 1);
    checks++;
    if (fill_level !== '0) begin errors++; $display("FAIL flush fill got %0d exp 0", fill_level); end
    step(1, 12'h7FF, 12'h001, 0, 0);
    step(1, 12'h800, 12'h002, 0, 0);
    for (int j = 2; j < N; j++) step(1, j == 2 ? 12'h000 : DW'($urandom), DW'($urandom), 0, 0);
    checks += 5;
    if (frame_valid !== 1'b1) begin errors++; $display("FAIL flush valid got %b exp 1", frame_valid); end
    if (frame_real[0 +: DW] !== 12'h7FF) begin errors++; $display("FAIL flush elem0 got %h exp 7ff", frame_real[0 +: DW]); end
    if (frame_real[4*DW +: DW] !== 12'h800) begin errors++; $display("FAIL flush elem4 got %h exp 800", frame_real[4*DW +: DW]); end
    if (frame_real !== fq[0].re) begin errors++; $display("FAIL flush re got %h exp %h", frame_real, fq[0].re); end
    if (frame_img !== fq[0].im) begin errors++; $display("FAIL flush im got %h exp %h", frame_img, fq[0].im); end
  endtask
  task automatic test_extremes();
    drain();
    for (int j = 0; j < N; j++) step(1, $urandom % 2 ? 12'h800 : 12'h7FF, $urandom % 2 ? 12'h800 : 12'h7FF, 0, 0);
    checks += 2;
    if (frame_real !== fq[0].re) begin errors++; $display("FAIL extremes re got %h exp %h", frame_real, fq[0].re); end
    if (frame_img !== fq[0].im) begin errors++; $display("FAIL extremes im got %h exp %h", frame_img, fq[0].im); end
  endtask
  task automatic test_async_reset();
    drain();
    for (int j = 0; j < N + 5; j++) step(1, DW'($urandom), DW'($urandom), 0, 0);
    checks += 2;
    if (fill_level !== 3'd5) begin errors++; $display("FAIL arst pre fill got %0d exp 5", fill_level); end
    if (frame_valid !== 1'b1) begin errors++; $display("FAIL arst pre valid got %b exp 1", frame_valid); end
    #2 rst = 1;
    #1;
    checks += 3;
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL arst valid got %b exp 0", frame_valid); end
    if (sample_ready !== 1'b1) begin errors++; $display("FAIL arst ready got %b exp 1", sample_ready); end
    if (fill_level !== '0) begin errors++; $display("FAIL arst fill got %0d exp 0", fill_level); end
    pr.delete(); pi.delete(); fq.delete();
    @(negedge clk);
    rst = 0;
    for (int j = 1; j <= N; j++) step(1, DW'(j), DW'($urandom), 0, 0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (frame_real[DW*k +: DW] !== seq_exp[k]) begin errors++; $display("FAIL arst elem%0d got %0d exp %0d", k, frame_real[DW*k +: DW], seq_exp[k]); end
    end
  endtask
  task automatic test_random();
    for (int j = 0; j < 400; j++) begin
      step($urandom % 4 != 0, DW'($urandom), DW'($urandom), $urandom % 3 == 0, $urandom % 20 == 0);
      checks += 3;
      if (sample_ready !== (fq.size() < 2)) begin errors++; $display("FAIL rand ready j%0d got %b exp %b", j, sample_ready, fq.size() < 2); end
      if (frame_valid !== (fq.size() > 0)) begin errors++; $display("FAIL rand valid j%0d got %b exp %b", j, frame_valid, fq.size() > 0); end
      if (fill_level !== LW'(pr.size())) begin errors++; $display("FAIL rand fill j%0d got %0d exp %0d", j, fill_level, pr.size()); end
      if (fq.size() > 0) begin
        checks++;
        if (frame_real !== fq[0].re || frame_img !== fq[0].im) begin errors++; $display("FAIL rand frame j%0d got %h exp %h", j, frame_real, fq[0].re); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_extremes();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
